io_initiator: RTL and testbench
===============================

IO_INITIATOR -- requirements
Module: io_initiator

Interface
REQ-001 Parameter QUEUE_DEPTH, default 2, request-queue entries; power of two, >=2.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, cycles an issued request may wait for ready.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 core_req_valid  input  1  core offers an IO request.
REQ-006 core_req_ready  output  1  queue accepts the request this cycle.
REQ-007 core_req_write  input  1  1 = write, 0 = read.
REQ-008 core_req_addr  input  32  IO address.
REQ-009 core_req_data  input  32  write data.
REQ-010 core_resp_valid  output  1  one-cycle pulse: a request completed.
REQ-011 core_resp_data  output  32  data returned by the responder.
REQ-012 core_resp_err  output  1  completion was a timeout; qualified by core_resp_valid.
REQ-013 sysbus_o_io_valid  output  1  bus request valid.
REQ-014 sysbus_o_io_write  output  1  bus request is a write.
REQ-015 sysbus_o_io_addr  output  32  bus address.
REQ-016 sysbus_o_io_data  output  32  bus write data.
REQ-017 sysbus_i_io_ready  input  1  responder ready; held high until valid drops.
REQ-018 sysbus_i_io_data  input  32  responder data; sampled when ready is high.

Function
REQ-019 Queue push on core_req_valid && core_req_ready; core_req_ready = !full; a same-cycle pop does not make a full queue accept a push.
REQ-020 Queue FIFO order; pointers wrap modulo QUEUE_DEPTH; occupancy counter distinguishes full from empty.
REQ-021 FSM states: IDLE, ISSUE, RELEASE.
REQ-022 IDLE: queue non-empty -> load head into sysbus_o_io_write/addr/data, assert sysbus_o_io_valid, go ISSUE; first request reaches the bus 1 cycle after push.
REQ-023 IDLE with sysbus_i_io_ready high (stale) does not issue; waits until ready is low.
REQ-024 ISSUE: valid, write, addr, data held stable until completion.
REQ-025 ISSUE and sysbus_i_io_ready high -> next cycle: valid low, queue pop, core_resp_valid=1, core_resp_data=sysbus_i_io_data captured, core_resp_err=0, go RELEASE.
REQ-026 RELEASE: wait for sysbus_i_io_ready low, then IDLE; minimum 1 cycle in RELEASE, so back-to-back requests are spaced by >=2 cycles of valid low.
REQ-027 Writes complete identically to reads; core_resp_data carries whatever the responder returns.
REQ-028 core_resp_valid is high exactly one cycle per completed request, never otherwise.
REQ-029 core_resp_data holds its last value when core_resp_valid is low.
REQ-030 sysbus_o_io_addr/data/write hold the last issued values when valid is low.

Reset
REQ-031 rst high at any posedge: FSM -> IDLE, queue emptied, sysbus_o_io_valid=0, core_resp_valid=0, core_resp_err=0, core_resp_data=0, sysbus_o_io_addr/data/write=0, timeout counter=0.
REQ-032 Reset mid-ISSUE drops valid next cycle; the in-flight request is discarded with no response.
REQ-033 core_req_ready=0 while rst is high.

Configuration
REQ-034 Macro IO_INITIATOR_TIMEOUT_EN defined: 32-bit counter clears on entering ISSUE and increments each ISSUE cycle without ready; at TIMEOUT_CYCLES-1 with ready still low -> next cycle valid low, pop, core_resp_valid=1, core_resp_err=1, core_resp_data=0, go RELEASE.
REQ-035 Ready and timeout in the same cycle: ready wins, err=0.
REQ-036 Macro undefined: no counter, ISSUE waits indefinitely, core_resp_err tied 0.

Verification
REQ-037 Read 0xfe000010, responder returns 0x12345678 after 3 cycles -> one resp pulse, data 0x12345678, err 0, valid low 1 cycle after ready.
REQ-038 Two writes (0xfe000000 data 0x41, then 0x42) pushed back-to-back -> bus sees 0x41 then 0x42 in order, valid low >=2 cycles between, two resp pulses.
REQ-039 Push 3 requests with QUEUE_DEPTH=2 and responder stalled -> core_req_ready low on third push until first completion, then accepted.
REQ-040 With IO_INITIATOR_TIMEOUT_EN, TIMEOUT_CYCLES=8, responder silent -> valid high 8 cycles, then resp pulse err=1 data 0; next queued request proceeds.
REQ-041 rst asserted 2 cycles into ISSUE -> valid low next cycle, no resp pulse, queue empty, core_req_ready=1 after rst drops.
REQ-042 Responder holds ready high 4 cycles after valid drops -> FSM stays RELEASE, no new valid until ready low.

Source files
------------

// File: rtl/io_initiator.sv
// io_initiator: queues core IO requests and issues them one at a time on a
// valid/ready system bus, returning a one-cycle completion pulse per request.
// Optional feature: define IO_INITIATOR_TIMEOUT_EN to time out requests that
// wait TIMEOUT_CYCLES for ready; the completion then reports err=1, data=0.
module io_initiator #(
  parameter int QUEUE_DEPTH    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req_valid,
  output logic        core_req_ready,
  input  logic        core_req_write,
  input  logic [31:0] core_req_addr,
  input  logic [31:0] core_req_data,
  output logic        core_resp_valid,
  output logic [31:0] core_resp_data,
  output logic        core_resp_err,
  output logic        sysbus_o_io_valid,
  output logic        sysbus_o_io_write,
  output logic [31:0] sysbus_o_io_addr,
  output logic [31:0] sysbus_o_io_data,
  input  logic        sysbus_i_io_ready,
  input  logic [31:0] sysbus_i_io_data
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

  // request queue
  req_t           mem_q [QUEUE_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           full, push, pop;
  req_t           head;

  // bus / response registers
  state_t         state_q, state_d;
  logic           valid_q, valid_d;
  logic           write_q, write_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    data_q, data_d;
  logic           resp_valid_q, resp_valid_d;
  logic [31:0]    resp_data_q, resp_data_d;

`ifdef IO_INITIATOR_TIMEOUT_EN
  logic           err_q, err_d;
  logic [31:0]    tmo_q, tmo_d;
`endif

  assign full           = (count_q == CW'(QUEUE_DEPTH));
  // A pop in the same cycle never frees a slot for a push: ready looks only at full.
  assign core_req_ready = !full && !rst;
  assign push           = core_req_valid && core_req_ready;
  assign head           = mem_q[rd_ptr_q];

  // queue pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // queue storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {core_req_write, core_req_addr, core_req_data};
  end

  // issue FSM next-state: the head stays queued until its completion pops it
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    write_d      = write_q;
    addr_d       = addr_q;
    data_d       = data_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    pop          = 1'b0;
`ifdef IO_INITIATOR_TIMEOUT_EN
    err_d        = 1'b0;
    tmo_d        = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        // a ready still high from the last transfer must fall before issuing
        if (count_q != '0 && !sysbus_i_io_ready) begin
          valid_d = 1'b1;
          write_d = head.write;
          addr_d  = head.addr;
          data_d  = head.data;
          state_d = ISSUE;
`ifdef IO_INITIATOR_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      ISSUE: begin
        if (sysbus_i_io_ready) begin
          valid_d      = 1'b0;
          pop          = 1'b1;
          resp_valid_d = 1'b1;
          resp_data_d  = sysbus_i_io_data;
          state_d      = RELEASE;
        end
`ifdef IO_INITIATOR_TIMEOUT_EN
        else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
          valid_d      = 1'b0;
          pop          = 1'b1;
          resp_valid_d = 1'b1;
          resp_data_d  = '0;
          err_d        = 1'b1;
          state_d      = RELEASE;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
`endif
      end
      RELEASE: begin
        if (!sysbus_i_io_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers; reset discards any in-flight request without a response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      valid_q      <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
`ifdef IO_INITIATOR_TIMEOUT_EN
      err_q        <= 1'b0;
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
`ifdef IO_INITIATOR_TIMEOUT_EN
      err_q        <= err_d;
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign sysbus_o_io_valid = valid_q;
  assign sysbus_o_io_write = write_q;
  assign sysbus_o_io_addr  = addr_q;
  assign sysbus_o_io_data  = data_q;
  assign core_resp_valid   = resp_valid_q;
  assign core_resp_data    = resp_data_q;
`ifdef IO_INITIATOR_TIMEOUT_EN
  assign core_resp_err     = err_q;
`else
  assign core_resp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_io_initiator.sv
// tb_io_initiator: directed scoreboard bench for io_initiator. Stimulus pushes
// expected bus beats and responses into queues; a monitor pops and compares.
module tb_io_initiator;

`ifdef IO_INITIATOR_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req_valid = 1'b0, core_req_ready, core_req_write = 1'b0;
  logic [31:0] core_req_addr = '0, core_req_data = '0;
  logic        core_resp_valid, core_resp_err;
  logic [31:0] core_resp_data;
  logic        sysbus_o_io_valid, sysbus_o_io_write;
  logic [31:0] sysbus_o_io_addr, sysbus_o_io_data;
  logic        sysbus_i_io_ready;
  logic [31:0] sysbus_i_io_data;

  io_initiator #(.QUEUE_DEPTH(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_write(core_req_write), .core_req_addr(core_req_addr),
    .core_req_data(core_req_data),
    .core_resp_valid(core_resp_valid), .core_resp_data(core_resp_data),
    .core_resp_err(core_resp_err),
    .sysbus_o_io_valid(sysbus_o_io_valid), .sysbus_o_io_write(sysbus_o_io_write),
    .sysbus_o_io_addr(sysbus_o_io_addr), .sysbus_o_io_data(sysbus_o_io_data),
    .sysbus_i_io_ready(sysbus_i_io_ready), .sysbus_i_io_data(sysbus_i_io_data)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [64:0] exp_bus_q [$];   // {write, addr, data}
  logic [32:0] exp_rsp_q [$];   // {err, data}
  logic [31:0] rsp_data_q [$];  // what the responder returns, in order
  int  rsp_delay = 0, rsp_hold = 0, min_gap = 2, exp_hi_len = 0, resp_count = 0;
  bit  rsp_silent = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: checks completions, bus beats, spacing and timeout length
  initial begin
    bit pre_v, pre_r, pre_rst, last_v, have_prev;
    int low_cnt, hi_cnt;
    logic [64:0] e;
    logic [32:0] r;
    last_v = 0; have_prev = 0; low_cnt = 0; hi_cnt = 0;
    forever begin
      @(negedge clk); #1;
      pre_v = sysbus_o_io_valid; pre_r = sysbus_i_io_ready; pre_rst = rst;
      @(posedge clk); #1;
      if (pre_v && pre_r && !pre_rst) begin
        chk("valid_drop_after_ready", {31'd0, sysbus_o_io_valid}, 32'd0);
        chk("resp_pulse_after_ready", {31'd0, core_resp_valid}, 32'd1);
      end
      if (core_resp_valid) begin
        resp_count++;
        if (exp_rsp_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          r = exp_rsp_q.pop_front();
          chk("resp_data", core_resp_data, r[31:0]);
          chk("resp_err", {31'd0, core_resp_err}, {31'd0, r[32]});
        end
      end
      if (sysbus_o_io_valid && !last_v) begin
        if (have_prev) chk("valid_low_gap_ok", {31'd0, low_cnt >= min_gap}, 32'd1);
        have_prev = 1; hi_cnt = 0;
        if (exp_bus_q.size() == 0) begin
          chk("unexpected_bus_req", 32'd1, 32'd0);
        end else begin
          e = exp_bus_q.pop_front();
          chk("bus_write", {31'd0, sysbus_o_io_write}, {31'd0, e[64]});
          chk("bus_addr", sysbus_o_io_addr, e[63:32]);
          chk("bus_data", sysbus_o_io_data, e[31:0]);
        end
      end
      if (!sysbus_o_io_valid && last_v) begin
        if (exp_hi_len != 0) begin
          chk("valid_high_cycles", hi_cnt, exp_hi_len);
          exp_hi_len = 0;
        end
        low_cnt = 0;
      end
      if (sysbus_o_io_valid) hi_cnt++; else low_cnt++;
      last_v = sysbus_o_io_valid;
    end
  end

  // responder: answers after rsp_delay, keeps ready rsp_hold cycles past valid drop
  initial begin
    sysbus_i_io_ready = 1'b0;
    sysbus_i_io_data  = '0;
    forever begin
      @(negedge clk);
      if (sysbus_o_io_valid && !rsp_silent && !rst) begin
        repeat (rsp_delay) @(negedge clk);
        if (sysbus_o_io_valid && !rst) begin
          sysbus_i_io_ready = 1'b1;
          sysbus_i_io_data  = (rsp_data_q.size() != 0) ? rsp_data_q.pop_front() : 32'hdeadbeef;
          for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!sysbus_o_io_valid) break;
          end
          repeat (rsp_hold) @(negedge clk);
          sysbus_i_io_ready = 1'b0;
        end
      end
    end
  end

  task automatic push_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rd, input bit terr);
    bit ok;
    ok = 0;
    @(negedge clk);
    core_req_valid = 1'b1; core_req_write = w; core_req_addr = a; core_req_data = d;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (core_req_ready) begin
        @(posedge clk);
        exp_bus_q.push_back({w, a, d});
        if (terr) exp_rsp_q.push_back({1'b1, 32'h0});
        else begin
          exp_rsp_q.push_back({1'b0, rd});
          rsp_data_q.push_back(rd);
        end
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    #1 core_req_valid = 1'b0;
    if (!ok) chk("push_accepted", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    bit done;
    done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (exp_rsp_q.size() == 0 && !sysbus_o_io_valid && !sysbus_i_io_ready) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("drain_in_time", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int base;
    bit seen;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_valid", {31'd0, sysbus_o_io_valid}, 32'd0);
    chk("rst_resp_valid", {31'd0, core_resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, core_resp_err}, 32'd0);
    chk("rst_resp_data", core_resp_data, 32'd0);
    chk("rst_bus_addr", sysbus_o_io_addr, 32'd0);
    chk("rst_bus_data", sysbus_o_io_data, 32'd0);
    chk("rst_req_ready_low", {31'd0, core_req_ready}, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("req_ready_after_rst", {31'd0, core_req_ready}, 32'd1);

    // single read, responder answers 3 cycles later
    rsp_delay = 3;
    push_req(1'b0, 32'hfe000010, 32'h0, 32'h12345678, 1'b0);
    wait_done();
    chk("resp_data_holds", core_resp_data, 32'h12345678);

    // two back-to-back writes, ordered and spaced
    rsp_delay = 0;
    push_req(1'b1, 32'hfe000000, 32'h41, 32'haaaa0001, 1'b0);
    push_req(1'b1, 32'hfe000000, 32'h42, 32'hbbbb0002, 1'b0);
    wait_done();
    chk("hold_bus_addr", sysbus_o_io_addr, 32'hfe000000);
    chk("hold_bus_data", sysbus_o_io_data, 32'h42);
    chk("hold_bus_write", {31'd0, sysbus_o_io_write}, 32'd1);
    chk("hold_resp_data", core_resp_data, 32'hbbbb0002);
    chk("hold_resp_valid_low", {31'd0, core_resp_valid}, 32'd0);

    // full queue with a stalled responder
    rsp_silent = 1'b1;
    push_req(1'b0, 32'hfe000100, 32'h0, 32'h11110001, 1'b0);
    push_req(1'b0, 32'hfe000104, 32'h0, 32'h11110002, 1'b0);
    repeat (5) @(negedge clk);
    #1 chk("full_req_ready_low", {31'd0, core_req_ready}, 32'd0);
    base = resp_count;
    rsp_silent = 1'b0;
    push_req(1'b1, 32'hfe000108, 32'h99, 32'h11110003, 1'b0);
    #2 chk("third_push_after_completion", resp_count - base, 32'd1);
    wait_done();

    // responder keeps ready high 4 cycles after valid drops
    rsp_hold = 4;
    min_gap  = 6;
    push_req(1'b0, 32'hfe000200, 32'h0, 32'h22220001, 1'b0);
    push_req(1'b0, 32'hfe000204, 32'h0, 32'h22220002, 1'b0);
    wait_done();
    rsp_hold = 0;
    min_gap  = 2;

`ifdef IO_INITIATOR_TIMEOUT_EN
    // silent responder: first request times out, second then proceeds
    rsp_silent = 1'b1;
    exp_hi_len = 8;
    base = resp_count;
    push_req(1'b0, 32'hfe000300, 32'h0, 32'h0, 1'b1);
    push_req(1'b0, 32'hfe000304, 32'h0, 32'h33330002, 1'b0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (resp_count != base) begin seen = 1; break; end
    end
    chk("timeout_resp_seen", {31'd0, seen}, 32'd1);
    rsp_silent = 1'b0;
    wait_done();
`endif

    // reset two cycles into ISSUE discards the request
    rsp_silent = 1'b1;
    push_req(1'b0, 32'hfe000400, 32'h0, 32'h44440001, 1'b0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (sysbus_o_io_valid) begin seen = 1; break; end
    end
    chk("issue_before_reset", {31'd0, seen}, 32'd1);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    exp_rsp_q.delete();
    rsp_data_q.delete();
    #1 chk("req_ready_low_in_rst", {31'd0, core_req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rst_drops_valid", {31'd0, sysbus_o_io_valid}, 32'd0);
    chk("rst_no_resp", {31'd0, core_resp_valid}, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("req_ready_after_mid_rst", {31'd0, core_req_ready}, 32'd1);
    rsp_silent = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (sysbus_o_io_valid || core_resp_valid) seen = 1;
    end
    chk("queue_empty_after_rst", {31'd0, seen}, 32'd0);

    chk("bus_queue_drained", exp_bus_q.size(), 32'd0);
    chk("resp_queue_drained", exp_rsp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

endmodule
